dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//   Bridges the core's single-cycle data port (data_ce_o/data_we_o/data_addr_o/data_o/data_i)
//   to a multi-cycle data memory with a req/ack handshake. Sits directly downstream of the
//   core's MEM stage. Registers each access and holds the request until the memory acks or
//   the timeout expires. Drives stall_o back to the core so the pipeline freezes meanwhile.
// PARAMETERS
//   ADDR_W    32            address width
//   DATA_W    32            data width
//   TIMEOUT   16            max cycles in REQ before abort (>=2)
//   ERR_DATA  32'hDEAD_BEEF read data returned on timeout
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       reset, asynchronous, active-low
//   core_ce     in   1       core read request (memRead)
//   core_we     in   1       core write request (memWrite)
//   core_addr   in   ADDR_W  byte address from core
//   core_wdata  in   DATA_W  store data from core
//   core_rdata  out  DATA_W  load data to core (registered)
//   stall_o     out  1       freeze pipeline while high
//   bus_err     out  1       one-cycle pulse on timeout abort
//   mem_req     out  1       memory request (registered)
//   mem_we      out  1       1 = write, 0 = read (registered)
//   mem_addr    out  ADDR_W  word-aligned address, bits [1:0] = 0 (registered)
//   mem_wdata   out  DATA_W  write data (registered)
//   mem_ack     in   1       single-cycle completion pulse from memory
//   mem_rdata   in   DATA_W  read data, valid in the mem_ack cycle
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE. mem_req, mem_we, bus_err = 0. mem_addr, mem_wdata,
//     core_rdata = 0. Timeout counter = 0. stall_o = 0.
//   Reset mid-access: abandons the transaction immediately; no bus_err.
//   FSM states: IDLE, REQ, DONE.
//   IDLE:
//     - core_we|core_ce high: latch the access (mem_we=core_we, addr with [1:0]=0, wdata),
//       set mem_req, clear counter, go to REQ.
//     - stall_o is combinationally high in this cycle, so the core does not advance.
//     - core_we has priority when both are high: the access is a write.
//     - No request: stay in IDLE, stall_o=0.
//   REQ:
//     - stall_o=1. mem_req and all mem_* outputs stay stable.
//     - mem_ack=1: capture mem_rdata into core_rdata (reads only; writes leave core_rdata
//       unchanged), clear mem_req, go to DONE.
//     - Otherwise counter++. When counter==TIMEOUT-1 with no ack: clear mem_req, pulse
//       bus_err for 1 cycle, core_rdata=ERR_DATA (reads only), go to DONE.
//     - Ack and timeout in the same cycle: ack wins, no bus_err.
//   DONE:
//     - stall_o=0 for exactly 1 cycle; the core samples core_rdata and advances.
//     - core_* inputs in this cycle belong to the completed access and are ignored.
//     - Next state: IDLE.
//   mem_ack outside REQ (late ack after abort, spurious ack) is ignored.
//   Latency: access whose ack arrives N cycles after mem_req rises -> stall_o high N+1
//     cycles; back-to-back accesses cost N+2 cycles each.
//   core_rdata holds its value until the next read completion.
// TESTING
//   1. Read, ack 1 cycle after mem_req: addr=0x104, mem_rdata=0x1234_5678 -> stall 2 cycles,
//      core_rdata=0x1234_5678 in DONE, mem_req high exactly 1 cycle.
//   2. Write, addr=0x103, wdata=0xA5A5_0F0F, ack after 3 -> mem_addr=0x100, mem_we=1,
//      mem_wdata stable until ack, core_rdata unchanged.
//   3. Read, no ack, TIMEOUT=16 -> mem_req drops after 16 cycles, bus_err 1-cycle pulse,
//      core_rdata=0xDEAD_BEEF, late ack 2 cycles later ignored.
//   4. Back-to-back load then store, ack=1 cycle each -> second mem_req rises 1 cycle after
//      DONE, no access lost or duplicated.
//   5. Ack arrives in the same cycle as timeout expiry -> data from mem_rdata, bus_err stays 0.
//   6. rst low mid-REQ -> mem_req=0, stall_o=0 immediately; after release, new read starts
//      from IDLE.

Source files
------------

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - single-cycle core data port to req/ack data memory bridge
module dmem_bridge #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_ce,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              stall_o,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             core_access;
    logic             unused_addr_bits;

    // Memory is word addressed; the byte offset bits are dropped.
    assign unused_addr_bits = ^core_addr[1:0];
    assign core_access      = core_ce | core_we;

    // Stall must rise in the same cycle the core presents the access, so it
    // cannot wait for the registered state; reset forces it low regardless.
    assign stall_o = rst & ((state == REQ) | ((state == IDLE) & core_access));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= core_we;
                        mem_addr  <= {core_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= core_wdata;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // An ack landing on the final timeout cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            core_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_MAX) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!mem_we) begin
                            core_rdata <= ERR_DATA;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_ce = 1'b0;
    logic        core_we = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        stall_o;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int req_rises = 0;
    logic req_q = 1'b0;

    dmem_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_ce   (core_ce),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .stall_o   (stall_o),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_q <= mem_req;
        if (mem_req && !req_q) req_rises <= req_rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one access, ack it in REQ cycle ack_at (0 = never), stop in the DONE cycle.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at, input logic [31:0] rd,
                          input int exp_gap, input int exp_stall, input int exp_reqs,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int gap;
        int stalls;
        int reqs;
        gap    = 0;
        stalls = 0;
        reqs   = 0;
        core_we    = we;
        core_ce    = !we;
        core_addr  = addr;
        core_wdata = wdata;
        #1;
        while (!stall_o && gap < 4) begin
            @(posedge clk); #1;
            gap++;
        end
        while (stall_o && stalls < 40) begin
            stalls++;
            if (mem_req) begin
                reqs++;
                chk({tag, "_maddr"}, mem_addr, addr & 32'hFFFF_FFFC);
                chk({tag, "_mwe"}, {31'd0, mem_we}, {31'd0, we});
                chk({tag, "_mwdata"}, mem_wdata, wdata);
                if (reqs == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
        chk({tag, "_gap"}, gap, exp_gap);
        chk({tag, "_stall_cycles"}, stalls, exp_stall);
        chk({tag, "_req_cycles"}, reqs, exp_reqs);
        chk({tag, "_done_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_rdata"}, core_rdata, exp_rdata);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, exp_err});
    endtask

    task automatic idle_cycle();
        core_ce = 1'b0;
        core_we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: read, ack in first REQ cycle
        access("t1", 1'b0, 32'h104, 32'h0, 1, 32'h1234_5678, 0, 2, 1, 32'h1234_5678, 1'b0);
        idle_cycle();

        // 2: write to unaligned address, ack in third REQ cycle
        access("t2", 1'b1, 32'h103, 32'hA5A5_0F0F, 3, 32'h5555_AAAA, 0, 4, 3, 32'h1234_5678, 1'b0);
        idle_cycle();

        // 3: read with no ack, then a late ack while idle
        access("t3", 1'b0, 32'h208, 32'h0, 0, 32'h0, 0, 17, 16, 32'hDEAD_BEEF, 1'b1);
        idle_cycle();
        chk("t3_err_pulse", {31'd0, bus_err}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("t3_late_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("t3_late_req", {31'd0, mem_req}, 32'd0);
        chk("t3_late_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("t3_late_err", {31'd0, bus_err}, 32'd0);

        // 4: back-to-back load then store; next request is presented during DONE
        access("t4a", 1'b0, 32'h40, 32'h0, 1, 32'h0000_00AA, 0, 2, 1, 32'h0000_00AA, 1'b0);
        access("t4b", 1'b1, 32'h44, 32'h1111_2222, 1, 32'h0, 1, 2, 1, 32'h0000_00AA, 1'b0);
        idle_cycle();
        chk("t4_idle_req", {31'd0, mem_req}, 32'd0);

        // 5: ack on the same cycle the timeout expires
        access("t5", 1'b0, 32'h30C, 32'h0, 16, 32'h7777_8888, 0, 17, 16, 32'h7777_8888, 1'b0);
        idle_cycle();

        // 6: reset asserted mid-REQ, then a fresh read
        core_ce   = 1'b1;
        core_addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_in_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
        chk("t6_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("t6_rst_err", {31'd0, bus_err}, 32'd0);
        chk("t6_rst_rdata", core_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        access("t6", 1'b0, 32'h300, 32'h0, 1, 32'hCAFE_F00D, 0, 2, 1, 32'hCAFE_F00D, 1'b0);
        idle_cycle();

        chk("req_rises_total", req_rises, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
